// File: rtl/piso_serializer.sv
// Parallel-in, serial-out word serializer feeding a downstream SIPO stage.
// Accepts a word on a valid/ready handshake and shifts it out one bit per clock.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             load_s;

  // Move the register one place toward the output bit, filling with zero.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return v[WIDTH-1];
    end else begin
      return v[0];
    end
  endfunction

  // Next-state computation for state, shift register and bit counter.
  always_comb begin
    load_s  = din_valid && din_ready;
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_s = SHIFT;
          shreg_s = din;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
          shreg_s = '0;
          cnt_s   = '0;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          if (load_s) begin
            state_s = SHIFT;
            shreg_s = din;
            cnt_s   = '0;
          end else begin
            state_s = IDLE;
            shreg_s = '0;
            cnt_s   = '0;
          end
        end else begin
          state_s = SHIFT;
          shreg_s = shift_toward_out(shreg_r);
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        shreg_s = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they never see inputs combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      cnt_r      <= '0;
      din_ready  <= 1'b1;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      cnt_r      <= cnt_s;
      din_ready  <= (state_s == IDLE) || (cnt_s == CNT_LAST);
      sout       <= (state_s == SHIFT) ? out_bit(shreg_s) : 1'b0;
      sout_valid <= (state_s == SHIFT);
      frame_done <= (state_s == SHIFT) && (cnt_s == CNT_LAST);
      busy       <= (state_s == SHIFT);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed vector table, hand-written corner cases,
// and randomized traffic against a queue-based bit-stream model (both bit orders).
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic       din_valid;

  logic m_rdy, m_sout, m_sv, m_fd, m_busy;
  logic l_rdy, l_sout, l_sv, l_fd, l_busy;

  logic [3:0] sipo;
  int         errors;
  int         checks;

  typedef struct packed {
    logic [3:0] din;
    logic       v;
    logic [4:0] exp;
    logic       chk_sipo;
    logic [3:0] sipo;
  } vec_t;

  vec_t tbl [23];

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(m_rdy), .sout(m_sout), .sout_valid(m_sv),
    .frame_done(m_fd), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(l_rdy), .sout(l_sout), .sout_valid(l_sv),
    .frame_done(l_fd), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit SIPO that shifts toward its MSB every edge.
  always @(posedge clk) sipo <= {sipo[2:0], m_sout};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] d, input logic v, input logic [4:0] e,
                              input logic cs, input logic [3:0] s);
    vec_t r;
    r.din = d; r.v = v; r.exp = e; r.chk_sipo = cs; r.sipo = s;
    return r;
  endfunction

  // Expected {sout, sout_valid, frame_done, busy, din_ready} from pending-bit count.
  function automatic logic [4:0] model_out(input int sz, input logic front);
    return {(sz > 0) ? front : 1'b0, sz > 0, sz == 1, sz > 0, sz <= 1};
  endfunction

  initial begin
    logic q_m [$];
    logic q_l [$];
    logic [3:0] words [$];
    logic lsb_seq [4];
    logic held, rdy, acc, ending;
    logic [3:0] w;

    errors = 0;
    checks = 0;
    reset = 1'b0;
    din = 4'h0;
    din_valid = 1'b0;
    sipo = 4'h0;

    // Async reset applied with the clock idle must take effect at once.
    #2 reset = 1'b1;
    #1;
    check("reset_now", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b00001);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_%0d", i), {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b00001);
    end

    tbl[0]  = mk(4'b1011, 1'b1, 5'b11010, 1'b0, 4'h0);
    tbl[1]  = mk(4'b0000, 1'b0, 5'b01010, 1'b0, 4'h0);
    tbl[2]  = mk(4'b0000, 1'b0, 5'b11010, 1'b0, 4'h0);
    tbl[3]  = mk(4'b0000, 1'b0, 5'b11111, 1'b0, 4'h0);
    tbl[4]  = mk(4'b0000, 1'b0, 5'b00001, 1'b1, 4'b1011);
    tbl[5]  = mk(4'b1011, 1'b1, 5'b11010, 1'b0, 4'h0);
    tbl[6]  = mk(4'b0000, 1'b0, 5'b01010, 1'b0, 4'h0);
    tbl[7]  = mk(4'b0000, 1'b0, 5'b11010, 1'b0, 4'h0);
    tbl[8]  = mk(4'b0000, 1'b0, 5'b11111, 1'b0, 4'h0);
    tbl[9]  = mk(4'b0110, 1'b1, 5'b01010, 1'b1, 4'b1011);
    tbl[10] = mk(4'b0000, 1'b0, 5'b11010, 1'b0, 4'h0);
    tbl[11] = mk(4'b0000, 1'b0, 5'b11010, 1'b0, 4'h0);
    tbl[12] = mk(4'b0000, 1'b0, 5'b01111, 1'b0, 4'h0);
    tbl[13] = mk(4'b0000, 1'b0, 5'b00001, 1'b1, 4'b0110);
    tbl[14] = mk(4'b1011, 1'b1, 5'b11010, 1'b0, 4'h0);
    tbl[15] = mk(4'b0110, 1'b1, 5'b01010, 1'b0, 4'h0);
    tbl[16] = mk(4'b0110, 1'b1, 5'b11010, 1'b0, 4'h0);
    tbl[17] = mk(4'b0110, 1'b1, 5'b11111, 1'b0, 4'h0);
    tbl[18] = mk(4'b0110, 1'b1, 5'b01010, 1'b1, 4'b1011);
    tbl[19] = mk(4'b0000, 1'b0, 5'b11010, 1'b0, 4'h0);
    tbl[20] = mk(4'b0000, 1'b0, 5'b11010, 1'b0, 4'h0);
    tbl[21] = mk(4'b0000, 1'b0, 5'b01111, 1'b0, 4'h0);
    tbl[22] = mk(4'b0000, 1'b0, 5'b00001, 1'b1, 4'b0110);

    for (int i = 0; i < 23; i++) begin
      din = tbl[i].din;
      din_valid = tbl[i].v;
      tick();
      check($sformatf("tbl_%0d", i), {m_sout, m_sv, m_fd, m_busy, m_rdy}, tbl[i].exp);
      if (tbl[i].chk_sipo) check($sformatf("sipo_%0d", i), sipo, tbl[i].sipo);
    end

    // Reset two bits into a frame: the partial frame vanishes with no frame_done.
    din = 4'b1111;
    din_valid = 1'b1;
    tick();
    check("rst_mid_b0", m_sout, 1'b1);
    din_valid = 1'b0;
    tick();
    check("rst_mid_b1", m_sout, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_now", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b00001);
    din = 4'b0101;
    din_valid = 1'b1;
    tick();
    check("rst_hold", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b00001);
    reset = 1'b0;
    tick();
    check("post_rst_b0", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b01010);
    din_valid = 1'b0;
    tick();
    check("post_rst_b1", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b11010);
    tick();
    check("post_rst_b2", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b01010);
    tick();
    check("post_rst_b3", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b11111);
    tick();
    check("post_rst_idle", {m_sout, m_sv, m_fd, m_busy, m_rdy}, 5'b00001);

    // LSB-first ordering: 1011 goes out as 1,1,0,1.
    lsb_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
    din = 4'b1011;
    din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      din_valid = 1'b0;
      check($sformatf("lsb_b%0d", k), {l_sout, l_sv, l_fd, l_busy, l_rdy},
            {lsb_seq[k], 1'b1, k == 3, 1'b1, k == 3});
    end
    tick();
    check("lsb_idle", {l_sout, l_sv, l_fd, l_busy, l_rdy}, 5'b00001);

    // Random traffic against a pending-bit queue model of both bit orders.
    held = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!held) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din = 4'($urandom);
      end
      rdy = (q_m.size() <= 1);
      acc = din_valid && rdy;
      ending = (q_m.size() == 1);
      w = din;
      tick();
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (acc) begin
        for (int b = 3; b >= 0; b--) q_m.push_back(w[b]);
        for (int b = 0; b < 4; b++) q_l.push_back(w[b]);
        words.push_back(w);
      end
      if (ending) check($sformatf("rnd_sipo_%0d", c), sipo, words.pop_front());
      check($sformatf("rnd_msb_%0d", c), {m_sout, m_sv, m_fd, m_busy, m_rdy},
            model_out(q_m.size(), (q_m.size() > 0) ? q_m[0] : 1'b0));
      check($sformatf("rnd_lsb_%0d", c), {l_sout, l_sv, l_fd, l_busy, l_rdy},
            model_out(q_l.size(), (q_l.size() > 0) ? q_l[0] : 1'b0));
      held = din_valid && !acc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out word serializer that feeds the serial data input of the 4-bit SIPO shift register stage. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock, most significant bit first. After exactly WIDTH shifts, the downstream SIPO holds the original word on its parallel output. A one-cycle frame strobe marks the last bit, and back-to-back words stream with no idle gap.

## Interface
- WIDTH, 4: word width in bits; legal range is WIDTH ≥ 2.
- MSB_FIRST, 1: bit order.
  - 1 = din[WIDTH-1] is sent first. This lands the word unreversed in a SIPO that shifts toward its MSB.
  - 0 = din[0] is sent first.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- din  in  WIDTH  parallel word to serialize.
- din_valid  in  1  din is valid.
- din_ready  out  1  serializer can accept a word this cycle.
- sout  out  1  serial data; connects to the SIPO data input.
- sout_valid  out  1  sout carries a frame bit this cycle.
- frame_done  out  1  one-cycle pulse, high during the last bit of a frame.
- busy  out  1  state is SHIFT.

## Operation
- Internal state:
  - shreg[WIDTH-1:0] shift register.
  - cnt bit counter, $clog2(WIDTH) bits.
  - FSM with states IDLE and SHIFT.
- Load: a load occurs at a rising edge when din_valid && din_ready.
  - shreg ← din, cnt ← 0, state ← SHIFT.
- IDLE:
  - din_ready=1, sout=0, sout_valid=0, frame_done=0, busy=0.
- SHIFT:
  - sout = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); sout_valid=1; busy=1.
  - Each edge, shreg shifts one position toward the output bit with 0 fill, and cnt increments.
  - When cnt==WIDTH-1 (last bit): frame_done=1 and din_ready=1.
    - If din_valid: load the new word, stay in SHIFT.
    - Else: go to IDLE; shreg and cnt are cleared.
  - When cnt<WIDTH-1: din_ready=0. din_valid is ignored, and the source must hold din/din_valid until accepted.
- sout, sout_valid, frame_done and busy decode only from registered state; they carry no combinational path from inputs.
- din_ready depends only on state and cnt, never on din_valid.
- Reset (async, takes effect immediately, including mid-frame):
  - state=IDLE, shreg=0, cnt=0.
  - sout=0, sout_valid=0, frame_done=0, busy=0, din_ready=1.
  - Any partial frame is discarded; frame_done is not issued for it.
  - No load can occur while reset is high.
- After reset deasserts, the first load can occur at the first rising edge with din_valid=1.

## Timing
- Word accepted at edge N: bits appear on sout during cycles N+1 … N+WIDTH, one per cycle. Cycle k means the period after edge N+k-1.
- sout_valid is high for exactly WIDTH consecutive cycles per word.
- frame_done is high in cycle N+WIDTH only.
- Downstream SIPO (MSB_FIRST=1) samples at edges N+1 … N+WIDTH. After edge N+WIDTH its parallel output equals din.
- Latency from accept to first bit: 1 cycle. From accept to word complete at the SIPO: WIDTH cycles.
- Back-to-back: if the next word is valid during cycle N+WIDTH, it loads at edge N+WIDTH. Its first bit appears in cycle N+WIDTH+1, with no bubble. Sustained throughput is 1 word per WIDTH cycles.
- cnt wraps WIDTH-1 → 0 only through a load or a return to IDLE; it never free-runs.

## Test plan
- Reset values: assert reset mid-cycle with clk idle → immediately sout=0, sout_valid=0, frame_done=0, busy=0, din_ready=1. Deassert, hold din_valid=0 for 10 cycles → outputs stay idle.
- Single word (WIDTH=4, MSB_FIRST=1): din=4'b1011 accepted at edge N → sout=1,0,1,1 in cycles N+1..N+4. sout_valid high for 4 cycles. frame_done high only in cycle N+4. SIPO output = 4'b1011 after edge N+4. Serializer returns to IDLE in cycle N+5.
- Back-to-back: 4'b1011, then 4'b0110 valid from cycle N+4 → sout=1,0,1,1,0,1,1,0 across 8 contiguous cycles with sout_valid high throughout. frame_done in cycles N+4 and N+8. SIPO reads 1011 after edge N+4 and 0110 after edge N+8.
- Held request: din_valid held high with 4'b0110 during cycles N+1..N+3 of a frame → din_ready=0 and no load. The word is accepted at edge N+4 only, and the first frame's bits are unchanged.
- Reset mid-frame: accept 4'b1111, assert reset after 2 bits → sout=0 and sout_valid=0 at once, with no frame_done. A new word 4'b0101 after release serializes as 0,1,0,1.
- MSB_FIRST=0: din=4'b1011 → sout=1,1,0,1.
